// File: rtl/xbus_arbiter.sv
// xbus_arbiter: shares the single xbus slave port between the CPU memory
// interface (m0), disk DMA (m1) and chaos/tv DMA (m2). A four-state FSM
// grants one master at a time and drives its address, data and write flag
// onto the bus. It times out slaves that never acknowledge, reports the
// first timed-out address, and keeps back-to-back DMA from starving the CPU.
module xbus_arbiter #(
    parameter int TIMEOUT    = 63,
    parameter int STARVE_MAX = 4
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [2:0]  m_req,
    input  logic [2:0]  m_write,
    input  logic [65:0] m_addr,
    input  logic [95:0] m_wdata,
    output logic [2:0]  m_ack,
    output logic [2:0]  m_err,
    output logic [31:0] m_rdata,
    output logic        bus_req,
    output logic        bus_write,
    output logic [21:0] bus_addr,
    output logic [31:0] bus_dataout,
    input  logic [31:0] bus_datain,
    input  logic        bus_ack,
    output logic        err_valid,
    output logic [21:0] err_addr,
    input  logic        err_clr
);

    localparam int           ADDR_W       = 22;
    localparam int           DATA_W       = 32;
    localparam logic [5:0]   TMO_LIMIT    = 6'(TIMEOUT);
    localparam logic [2:0]   STARVE_LIMIT = 3'(STARVE_MAX);
    localparam logic [2:0]   STARVE_SAT   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [2:0]          starve_cnt_q, starve_cnt_d;
    logic [5:0]          tmo_cnt_q, tmo_cnt_d;
    logic                terr_q, terr_d;         // current access ended in a timeout
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_valid_q, err_valid_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    // Fields of the currently granted master and the next arbitration winner
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic                sel_req;
    logic [2:0]          gnt_onehot;
    logic [1:0]          winner;
    logic                cpu_forced;

    // Select the granted master's request fields
    always_comb begin
        sel_addr   = m_addr[ADDR_W-1:0];
        sel_wdata  = m_wdata[DATA_W-1:0];
        sel_write  = m_write[0];
        sel_req    = m_req[0];
        gnt_onehot = 3'b001;
        case (gnt_q)
            2'd1: begin
                sel_addr   = m_addr[2*ADDR_W-1:ADDR_W];
                sel_wdata  = m_wdata[2*DATA_W-1:DATA_W];
                sel_write  = m_write[1];
                sel_req    = m_req[1];
                gnt_onehot = 3'b010;
            end
            2'd2: begin
                sel_addr   = m_addr[3*ADDR_W-1:2*ADDR_W];
                sel_wdata  = m_wdata[3*DATA_W-1:2*DATA_W];
                sel_write  = m_write[2];
                sel_req    = m_req[2];
                gnt_onehot = 3'b100;
            end
            default: ;
        endcase
    end

    // Fixed priority m1 > m2 > m0, overridden for the CPU once DMA has starved it
    always_comb begin
        cpu_forced = m_req[0] && (starve_cnt_q == STARVE_LIMIT);
        winner     = 2'd0;
        if (cpu_forced) begin
            winner = 2'd0;
        end else if (m_req[1]) begin
            winner = 2'd1;
        end else if (m_req[2]) begin
            winner = 2'd2;
        end
    end

    // Next-state logic for the transaction FSM, timeout counter and error capture
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        terr_d      = terr_q;
        rdata_d     = rdata_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (|m_req) begin
                    state_d = S_GRANT;
                    gnt_d   = winner;
                end
            end
            S_GRANT: begin
                // Slave acks here are ignored; the access always spends time in WAIT
                state_d   = S_WAIT;
                tmo_cnt_d = '0;
            end
            S_WAIT: begin
                if (bus_ack) begin
                    // An ack in the timeout cycle still completes normally
                    state_d = S_DONE;
                    terr_d  = 1'b0;
                    if (!sel_write) begin
                        rdata_d = bus_datain;
                    end
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                    rdata_d = '1;
                    // Only the first timeout is recorded; a same-cycle clear drops it
                    if (!err_valid_q && !err_clr) begin
                        err_valid_d = 1'b1;
                        err_addr_d  = sel_addr;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                if (!sel_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end
    end

    // Count consecutive DMA grants issued while the CPU is waiting
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m_req[0]) begin
            starve_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            if (winner == 2'd0) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_SAT) begin
                starve_cnt_d = starve_cnt_q + 3'd1;
            end
        end
    end

    // Bus and master-side outputs decoded from the current state and grant
    always_comb begin
        bus_req     = (state_q == S_WAIT);
        bus_addr    = '0;
        bus_write   = 1'b0;
        bus_dataout = '0;
        m_ack       = '0;
        m_err       = '0;
        if (state_q != S_IDLE) begin
            bus_addr    = sel_addr;
            bus_write   = sel_write;
            bus_dataout = sel_wdata;
        end
        if (state_q == S_DONE) begin
            m_ack = gnt_onehot;
            if (terr_q) begin
                m_err = gnt_onehot;
            end
        end
        m_rdata   = rdata_q;
        err_valid = err_valid_q;
        err_addr  = err_addr_q;
    end

    // State and data registers with synchronous active-low reset
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'd0;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            terr_q       <= 1'b0;
            rdata_q      <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            terr_q       <= terr_d;
            rdata_q      <= rdata_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Testbench for xbus_arbiter: directed transactions with a scoreboard of
// expected completions and a monitor that checks each m_ack pulse.
module tb_xbus_arbiter;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  m_req = '0;
    logic [2:0]  m_write = '0;
    logic [65:0] m_addr = '0;
    logic [95:0] m_wdata = '0;
    logic [2:0]  m_ack;
    logic [2:0]  m_err;
    logic [31:0] m_rdata;
    logic        bus_req;
    logic        bus_write;
    logic [21:0] bus_addr;
    logic [31:0] bus_dataout;
    logic [31:0] bus_datain = '0;
    logic        bus_ack = 1'b0;
    logic        err_valid;
    logic [21:0] err_addr;
    logic        err_clr = 1'b0;

    xbus_arbiter #(.TIMEOUT(63), .STARVE_MAX(4)) dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .m_req       (m_req),
        .m_write     (m_write),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .m_rdata     (m_rdata),
        .bus_req     (bus_req),
        .bus_write   (bus_write),
        .bus_addr    (bus_addr),
        .bus_dataout (bus_dataout),
        .bus_datain  (bus_datain),
        .bus_ack     (bus_ack),
        .err_valid   (err_valid),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        int          m;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_dly = 1000;
    int   wcnt = 0;
    int   clr_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle: advance to the falling edge, then drive err_clr and the slave model
    task automatic tick();
        @(negedge mclk);
        err_clr = (cyc == clr_cyc);
        if (bus_req) begin
            bus_ack = (wcnt == ack_dly);
            wcnt++;
        end else begin
            bus_ack = 1'b0;
            wcnt = 0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge mclk);
            if (reset_n && (|m_ack) && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: m_ack=%b with empty scoreboard", m_ack);
                end else begin
                    e = sb.pop_front();
                    chk("ack_master", 32'(m_ack), 32'd1 << e.m);
                    chk("ack_err", 32'(m_err), e.err ? (32'd1 << e.m) : 32'd0);
                    chk("ack_rdata", m_rdata, e.rdata);
                    if (e.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev = reset_n && (|m_ack);
        end
    endtask

    // Single transaction from master m; lat is the hand-computed ack cycle offset
    task automatic txn(input int m, input logic w, input logic [21:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] din, input logic eerr,
                       input logic [31:0] erd, input int lat, input int clr_off, input string nm);
        int c0;
        bit seen;
        tick();
        m_addr[m*22 +: 22]  = a;
        m_wdata[m*32 +: 32] = wd;
        m_write[m]          = w;
        bus_datain          = din;
        ack_dly             = dly;
        c0                  = cyc;
        clr_cyc             = (clr_off >= 0) ? c0 + clr_off : -1;
        sb.push_back('{m, eerr, erd, c0 + lat});
        m_req[m] = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            tick();
            if (k == 2) begin
                chk({nm, "_bus_req"}, 32'(bus_req), 32'd1);
                chk({nm, "_bus_addr"}, 32'(bus_addr), 32'(a));
                chk({nm, "_bus_write"}, 32'(bus_write), 32'(w));
                chk({nm, "_bus_dataout"}, bus_dataout, wd);
            end
            if (m_ack[m]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_wait: actual=no m_ack in 200 cycles required=m_ack[%0d]", nm, m);
        end
        m_req[m] = 1'b0;
        clr_cyc  = -1;
        tick();
    endtask

    initial begin
        int ord[5];
        int who;
        bit seen;
        ord = '{1, 2, 1, 2, 0};
        fork
            monitor();
        join_none

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        reset_n = 1'b1;
        tick();

        // m0 read with ack in the first WAIT cycle
        txn(0, 1'b0, 22'o1234, 32'h0, 0, 32'hdeadbeef, 1'b0, 32'hdeadbeef, 3, -1, "t1_read");
        // m1 write acked in the third WAIT cycle: read data register unchanged
        txn(1, 1'b1, 22'o4000, 32'h12345678, 2, 32'h55555555, 1'b0, 32'hdeadbeef, 5, -1, "wr_keep");

        // All three hold requests: m1,m2,m1,m2 then the starved CPU
        bus_datain = 32'h600d0000;
        ack_dly    = 0;
        m_write    = '0;
        m_addr     = {22'o3000, 22'o2000, 22'o1000};
        for (int g = 0; g < 5; g++) sb.push_back('{ord[g], 1'b0, 32'h600d0000, -1});
        tick();
        m_req = 3'b111;
        for (int g = 0; g < 5; g++) begin
            seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
                tick();
                if (|m_ack) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL arb_ack_wait: actual=no m_ack in 50 cycles required=grant %0d", g);
                m_req = '0;
                break;
            end
            if (g == 4) begin
                m_req = '0;
            end else begin
                who = m_ack[1] ? 1 : (m_ack[2] ? 2 : 0);
                m_req[who] = 1'b0;
                tick();
                tick();
                m_req[who] = 1'b1;
            end
        end
        repeat (3) tick();

        // m2 write times out: error flagged, first address captured
        txn(2, 1'b1, 22'o17377777, 32'hcafef00d, 1000, 32'h0, 1'b1, 32'hffffffff, 66, -1, "t3_tmo");
        chk("t3_err_valid", 32'(err_valid), 32'd1);
        chk("t3_err_addr", 32'(err_addr), 32'(22'o17377777));

        // Second timeout keeps the first address
        txn(0, 1'b0, 22'o777, 32'h0, 1000, 32'h0, 1'b1, 32'hffffffff, 66, -1, "t4_tmo2");
        chk("t4_err_valid", 32'(err_valid), 32'd1);
        chk("t4_err_addr", 32'(err_addr), 32'(22'o17377777));

        // Third timeout with err_clr in the same cycle: flag cleared, new error dropped
        txn(1, 1'b0, 22'o555, 32'h0, 1000, 32'h0, 1'b1, 32'hffffffff, 66, 65, "t4_clr");
        chk("t4_clr_err_valid", 32'(err_valid), 32'd0);
        chk("t4_clr_err_addr", 32'(err_addr), 32'd0);

        // Ack in the cycle the timeout would fire: normal completion
        txn(2, 1'b0, 22'o2525, 32'h0, 63, 32'h0f0f1234, 1'b0, 32'h0f0f1234, 66, -1, "t5_race");
        chk("t5_err_valid", 32'(err_valid), 32'd0);

        // Reset during WAIT
        ack_dly = 1000;
        m_addr[21:0] = 22'o7070;
        m_write[0]   = 1'b0;
        tick();
        m_req[0] = 1'b1;
        tick();
        tick();
        chk("t6_wait_bus_req", 32'(bus_req), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("t6_bus_req", 32'(bus_req), 32'd0);
        chk("t6_m_ack", 32'(m_ack), 32'd0);
        chk("t6_bus_addr", 32'(bus_addr), 32'd0);
        chk("t6_m_rdata", m_rdata, 32'd0);
        m_req[0] = 1'b0;
        reset_n = 1'b1;
        repeat (4) tick();
        chk("t6_after_bus_req", 32'(bus_req), 32'd0);
        chk("t6_after_m_ack", 32'(m_ack), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
